// File: rtl/sd_pkg.sv
// sd_pkg: shared definitions for the sphere-decoder search controller.
// Holds the Q-format widths, the constellation point constants, the
// modulation encodings and the controller FSM state type.
package sd_pkg;

  // Q6.10 fixed-point format for one real or imaginary component
  localparam int INT_W  = 6;
  localparam int FRAC_W = 10;
  localparam int WIDTH  = INT_W + FRAC_W;

  // QPSK points sit at +/- 1/sqrt(2) ~= 724/1024 on each axis
  localparam logic [WIDTH-1:0] S_POS   = 16'h02D4;
  localparam logic [WIDTH-1:0] S_NEG   = 16'hFD2C;
  // BPSK points sit at +/- 1.0 on the real axis
  localparam logic [WIDTH-1:0] ONE_POS = 16'h0400;
  localparam logic [WIDTH-1:0] ONE_NEG = 16'hFC00;

  // Constellation select encodings
  localparam int MOD_BPSK = 0;
  localparam int MOD_QPSK = 1;

  // Level-search controller states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  // Number of candidate symbols searched per tree level
  function automatic int ncand_for(input int mod);
    return (mod == MOD_QPSK) ? 4 : 2;
  endfunction

endpackage

// File: rtl/sd_cand_rom.sv
// sd_cand_rom: combinational constellation lookup.
// Ports:
//   i_idx  - candidate index (0..3 for QPSK, 0..1 for BPSK)
//   o_sym  - candidate symbol {real, imag}, each WIDTH-bit two's complement
// Indices beyond the constellation size return zero.
module sd_cand_rom #(
  parameter int WIDTH = sd_pkg::WIDTH,
  parameter int MOD   = sd_pkg::MOD_QPSK
) (
  input  logic [1:0]         i_idx,
  output logic [2*WIDTH-1:0] o_sym
);
  import sd_pkg::*;

  logic [WIDTH-1:0] sym_re;
  logic [WIDTH-1:0] sym_im;

  always_comb begin
    sym_re = '0;
    sym_im = '0;
    if (MOD == MOD_QPSK) begin
      // Points walk counter-clockwise starting in the first quadrant
      case (i_idx)
        2'd0: begin sym_re = WIDTH'(S_POS); sym_im = WIDTH'(S_POS); end
        2'd1: begin sym_re = WIDTH'(S_NEG); sym_im = WIDTH'(S_POS); end
        2'd2: begin sym_re = WIDTH'(S_NEG); sym_im = WIDTH'(S_NEG); end
        default: begin sym_re = WIDTH'(S_POS); sym_im = WIDTH'(S_NEG); end
      endcase
    end else begin
      case (i_idx)
        2'd0:    sym_re = WIDTH'(ONE_POS);
        2'd1:    sym_re = WIDTH'(ONE_NEG);
        default: sym_re = '0;
      endcase
    end
  end

  assign o_sym = {sym_re, sym_im};

endmodule

// File: rtl/sd_candidate_issuer.sv
// sd_candidate_issuer: per-level search controller for the sphere decoder.
// Issues each constellation candidate into the complex_multiply -> accum ->
// PED datapath one at a time, collects the returned partial Euclidean
// distance, keeps the strict minimum and reports the winner.
// Ports:
//   i_clk, i_rst     - clock, asynchronous active-high reset
//   i_start          - start a level search (accepted only when idle)
//   i_radius         - unsigned squared search radius, sampled on start
//   o_cand_valid     - candidate strobe to the multiplier
//   o_cand_data      - candidate symbol {real, imag}
//   i_ped_valid      - PED result strobe
//   i_ped_data       - PED result; metric in the low WIDTH bits
//   o_busy           - search in progress
//   o_done           - one-cycle completion pulse
//   o_err            - a PED return timed out
//   o_found          - best metric is strictly inside the radius
//   o_best_idx       - winning candidate index
//   o_best_metric    - winning metric
module sd_candidate_issuer #(
  parameter int INT_W       = sd_pkg::INT_W,
  parameter int FRAC_W      = sd_pkg::FRAC_W,
  parameter int WIDTH       = INT_W + FRAC_W,
  parameter int MOD         = sd_pkg::MOD_QPSK,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_radius,
  output logic               o_cand_valid,
  output logic [2*WIDTH-1:0] o_cand_data,
  input  logic               i_ped_valid,
  input  logic [2*WIDTH-1:0] i_ped_data,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic               o_found,
  output logic [1:0]         o_best_idx,
  output logic [WIDTH-1:0]   o_best_metric
);
  import sd_pkg::*;

  localparam int               NCAND    = ncand_for(MOD);
  localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [1:0]       LAST_IDX = 2'(NCAND - 1);
  // The counter holds the number of silent WAIT cycles already seen, so the
  // timeout fires on the cycle that would make it reach TIMEOUT_CYC.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [WIDTH-1:0]   radius_q, radius_d;
  logic [WIDTH-1:0]   best_metric_q, best_metric_d;
  logic [1:0]         best_idx_q, best_idx_d;
  logic [CNT_W-1:0]   tcnt_q, tcnt_d;
  logic               err_q, err_d;
  logic               found_q, found_d;
  logic               done_q, done_d;
  logic [1:0]         out_idx_q, out_idx_d;
  logic [WIDTH-1:0]   out_metric_q, out_metric_d;

  logic [WIDTH-1:0]   ped_metric;
  logic [2*WIDTH-1:0] rom_sym;
  logic               unused_ped_hi;

  assign ped_metric    = i_ped_data[WIDTH-1:0];
  assign unused_ped_hi = ^i_ped_data[2*WIDTH-1:WIDTH];

  sd_cand_rom #(
    .WIDTH (WIDTH),
    .MOD   (MOD)
  ) u_rom (
    .i_idx (idx_q),
    .o_sym (rom_sym)
  );

  // Next-state logic: one candidate in flight at a time, so the datapath
  // never sees back-to-back strobes.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    radius_d      = radius_q;
    best_metric_d = best_metric_q;
    best_idx_d    = best_idx_q;
    tcnt_d        = tcnt_q;
    err_d         = err_q;
    found_d       = found_q;
    done_d        = 1'b0;
    out_idx_d     = out_idx_q;
    out_metric_d  = out_metric_q;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          radius_d      = i_radius;
          idx_d         = 2'd0;
          best_metric_d = '1;
          best_idx_d    = 2'd0;
          err_d         = 1'b0;
          found_d       = 1'b0;
          state_d       = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        tcnt_d  = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        // A return arriving on the timeout cycle takes priority
        if (i_ped_valid) begin
          // Strict compare so a tie keeps the lower index
          if (ped_metric < best_metric_q) begin
            best_metric_d = ped_metric;
            best_idx_d    = idx_q;
          end
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_ISSUE;
          end
        end else if (tcnt_q == TMO_LAST) begin
          tcnt_d  = tcnt_q + CNT_W'(1);
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tcnt_d = tcnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        done_d       = 1'b1;
        found_d      = !err_q && (best_metric_q < radius_q);
        out_idx_d    = best_idx_q;
        out_metric_d = best_metric_q;
        state_d      = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      radius_q      <= '0;
      best_metric_q <= '0;
      best_idx_q    <= '0;
      tcnt_q        <= '0;
      err_q         <= 1'b0;
      found_q       <= 1'b0;
      done_q        <= 1'b0;
      out_idx_q     <= '0;
      out_metric_q  <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      radius_q      <= radius_d;
      best_metric_q <= best_metric_d;
      best_idx_q    <= best_idx_d;
      tcnt_q        <= tcnt_d;
      err_q         <= err_d;
      found_q       <= found_d;
      done_q        <= done_d;
      out_idx_q     <= out_idx_d;
      out_metric_q  <= out_metric_d;
    end
  end

  // Candidate bus is only driven while issuing so idle cycles show zero
  assign o_cand_valid  = (state_q == ST_ISSUE);
  assign o_cand_data   = (state_q == ST_ISSUE) ? rom_sym : '0;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_done        = done_q;
  assign o_err         = err_q;
  assign o_found       = found_q;
  assign o_best_idx    = out_idx_q;
  assign o_best_metric = out_metric_q;

endmodule

// File: doc/sd_candidate_issuer.md
Name: sd_candidate_issuer

Overview:
- Search-side controller that sits at the other end of the complex_multiply -> accum -> PED datapath.
- For one tree level, it issues each constellation candidate symbol into the multiply pipe, one at a time.
- It collects the returned partial Euclidean distance for each candidate and keeps the strict minimum.
- When all candidates are done, it reports the best candidate index and metric, and whether that metric is inside the current search radius.

Parameters:
- INT_W, 6, integer bits of the Q-format.
- FRAC_W, 10, fractional bits of the Q-format.
- WIDTH, INT_W+FRAC_W, width of one real or imaginary component.
- MOD, 1, constellation select: 0 = BPSK (2 candidates), 1 = QPSK (4 candidates).
- TIMEOUT_CYC, 15, maximum cycles to wait for a PED return per candidate.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_start  in  1  one-cycle request to start a level search; accepted only in IDLE.
- i_radius  in  WIDTH  unsigned squared search radius; sampled on an accepted i_start.
- o_cand_valid  out  1  candidate strobe; drives the multiplier's i_valid.
- o_cand_data  out  2*WIDTH  candidate symbol {real, imag}; drives the multiplier's i_in_b.
- i_ped_valid  in  1  PED result strobe.
- i_ped_data  in  2*WIDTH  PED result word; the metric is bits [WIDTH-1:0], unsigned; upper bits are ignored.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  timeout flag; valid when o_done is high, held until the next accepted start.
- o_found  out  1  best metric < radius; valid when o_done is high, held.
- o_best_idx  out  2  index of the best candidate; held.
- o_best_metric  out  WIDTH  best metric; held.

Behaviour:
- Reset (asynchronous, any state, including mid-search):
  - State goes to IDLE.
  - All outputs are 0.
  - Internal best metric, index and timeout counter are cleared.
- Candidate table, in index order, Q6.10 two's complement, with S = 724 (0x02D4) and -S = 0xFD2C:
  - QPSK: 0 = (+S,+S), 1 = (-S,+S), 2 = (-S,-S), 3 = (+S,-S).
  - BPSK: 0 = (0x0400, 0), 1 = (0xFC00, 0).
  - NCAND = 2 for BPSK, 4 for QPSK.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - On i_start: latch i_radius, set idx=0, set best_metric = all ones, best_idx=0.
  - Clear o_err and o_found, then go to ISSUE.
- ISSUE (exactly one cycle):
  - o_cand_valid=1 and o_cand_data = table[idx].
  - Clear the timeout counter, then go to WAIT.
  - o_cand_valid is 0 in every other state. o_cand_data is 0 outside ISSUE.
- WAIT:
  - Each cycle without i_ped_valid increments the timeout counter.
  - On i_ped_valid: if metric < best_metric (strict, unsigned), update best_metric and best_idx. A tie keeps the lower index.
  - After the compare: if idx == NCAND-1, go to DONE; otherwise increment idx and go to ISSUE.
  - If the counter reaches TIMEOUT_CYC with no return: set o_err=1 and go to DONE. Partial best values are retained; o_found is forced to 0.
  - If i_ped_valid and the timeout occur in the same cycle, the return wins and no error is flagged.
- DONE (one cycle):
  - o_done=1.
  - o_found = (!err && best_metric < radius).
  - o_best_* and o_found/o_err hold until the next accepted start. Go to IDLE.
- Ignored inputs:
  - i_ped_valid outside WAIT is ignored.
  - i_start while o_busy is ignored; the running search is not disturbed.
- Timing:
  - Only one candidate is in flight at a time. This is required because PED cannot accept back-to-back i_valid.
  - Level latency = 1 (accept) + NCAND*(1 + L) + 1, where L is the datapath return latency.
  - Example: QPSK with L=6 gives 1 + 4*7 + 1 = 30 cycles from i_start to o_done.
- Width rules: the metric and radius are unsigned WIDTH-bit values. There is no saturation; the compare is exact.

Decomposition:
- Shared package sd_pkg holds:
  - the Q-format constants INT_W and FRAC_W;
  - the constellation constants S_POS, S_NEG, ONE_POS, ONE_NEG;
  - the MOD encodings;
  - the FSM state enum.
- One natural sub-module: sd_cand_rom, a combinational lookup from (MOD, idx) to a 2*WIDTH symbol.

Test Plan:
- QPSK, radius 0x0100, returned metrics 0x0050, 0x0020, 0x0080, 0x0030 -> o_done with best_idx=1, best_metric=0x0020, found=1, err=0. Issued o_cand_data sequence is 0x02D402D4, 0xFD2C02D4, 0xFD2CFD2C, 0x02D4FD2C.
- QPSK, radius 0x0010, metrics 0x0040, 0x0040, 0x0050, 0x0060 -> tie keeps best_idx=0, best_metric=0x0040, found=0.
- BPSK, radius 0x0200, metrics 0x0100 then 0x0090 -> exactly two candidate strobes (0x04000000, 0xFC000000), best_idx=1, found=1.
- QPSK, datapath stalls after the 2nd candidate (no i_ped_valid for 15 cycles) -> o_done with err=1, found=0, best retained from the first two returns.
- Stray i_ped_valid in IDLE and i_start pulsed during WAIT -> no state change, no extra o_cand_valid, result unaffected.
- i_rst asserted mid-WAIT -> all outputs 0 immediately (asynchronous); a fresh i_start after release completes normally in 30 cycles with L=6.
